// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// Decode and the regfile use REGNO_BITS from here as well.
// Contents:
//   - hazState_t : sequencer FSM state encoding.
//   - pipeCtl_t  : bundle of per-stage enable and flush strobes.
package pipeline_hazard_ctrl_pkg;

  localparam int REGNO_BITS = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2
  } hazState_t;

  typedef struct packed {
    logic enPc;
    logic enFd;
    logic flushFd;
    logic enDe;
    logic flushDe;
    logic enEm;
    logic enMw;
  } pipeCtl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Wrapping event counter used for the stall and flush performance counters.
// Ports:
//   clk, reset : clock and synchronous active-high clear.
//   en         : count this cycle.
//   cnt        : running count, wraps modulo 2^W.
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset)   cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// It detects three hazard kinds and drives the per-stage enable and flush strobes:
//   - load-use
//   - control redirect
//   - memory wait
// Outputs are combinational from the registered state and the current inputs.
// Ports:
//   Decode operands  : id_sr1, id_sr2, id_use_sr1, id_use_sr2.
//   EX-stage info    : ex_memtoReg, ex_dr, ex_redirect.
//   Memory handshake : mem_req, mem_ready.
//   Stage strobes    : en_pc, en_fd, flush_fd, en_de, flush_de, en_em, en_mw.
//   Status           : mem_err (sticky timeout).
//   Perf counters    : stall_cnt, flush_cnt.
module pipeline_hazard_ctrl #(
  parameter int REGNO_BITS  = pipeline_hazard_ctrl_pkg::REGNO_BITS,
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_BITS    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REGNO_BITS-1:0] id_sr1,
  input  logic [REGNO_BITS-1:0] id_sr2,
  input  logic                  id_use_sr1,
  input  logic                  id_use_sr2,
  input  logic                  ex_memtoReg,
  input  logic [REGNO_BITS-1:0] ex_dr,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  en_pc,
  output logic                  en_fd,
  output logic                  flush_fd,
  output logic                  en_de,
  output logic                  flush_de,
  output logic                  en_em,
  output logic                  en_mw,
  output logic                  mem_err,
  output logic [CNT_BITS-1:0]   stall_cnt,
  output logic [CNT_BITS-1:0]   flush_cnt
);
  import pipeline_hazard_ctrl_pkg::*;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  hazState_t      state, savedState, effState, nextState;
  logic [1:0]     bubbleCnt, nextBub;
  logic [TW-1:0]  toutCnt;
  logic           memErr, freeze, loadUse;
  pipeCtl_t       ctl;

  assign freeze = mem_req & ~mem_ready;

  // The cycle that leaves MEM_WAIT already behaves as the state that the
  // freeze interrupted. This way a stalled bubble sequence picks up exactly where it stopped.
  assign effState = (state == MEM_WAIT) ? savedState : state;

  assign loadUse = (effState == RUN) & ex_memtoReg & (ex_dr != '0) &
                   ((id_use_sr1 & (id_sr1 == ex_dr)) | (id_use_sr2 & (id_sr2 == ex_dr)));

  always_comb begin
    ctl       = '{enPc: 1'b1, enFd: 1'b1, flushFd: 1'b0, enDe: 1'b1,
                  flushDe: 1'b0, enEm: 1'b1, enMw: 1'b1};
    nextState = effState;
    nextBub   = bubbleCnt;
    if (reset) begin
      ctl.flushFd = 1'b1;
      ctl.flushDe = 1'b1;
    end else if (freeze) begin
      ctl       = '0;
      nextState = MEM_WAIT;
    end else if (ex_redirect) begin
      // The hazard instruction is squashed, so any pending bubbles are dropped.
      ctl.flushFd = 1'b1;
      ctl.flushDe = 1'b1;
      nextState   = RUN;
      nextBub     = '0;
    end else if (loadUse || effState == LOAD_USE) begin
      ctl.enPc    = 1'b0;
      ctl.enFd    = 1'b0;
      ctl.flushDe = 1'b1;
      if (effState == LOAD_USE) begin
        nextBub = bubbleCnt - 1'b1;
        if (bubbleCnt == 2'd1) nextState = RUN;
      end else if (LU_BUBBLES > 1) begin
        nextState = LOAD_USE;
        nextBub   = 2'(LU_BUBBLES - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      savedState <= RUN;
      bubbleCnt  <= '0;
      toutCnt    <= '0;
      memErr     <= 1'b0;
    end else begin
      state     <= nextState;
      bubbleCnt <= nextBub;
      if (freeze) begin
        if (state != MEM_WAIT) savedState <= state;
        // Saturates at the limit; mem_err is sticky, so no further counting is needed.
        if (toutCnt == TW'(MEM_TIMEOUT)) memErr <= 1'b1;
        else                             toutCnt <= toutCnt + 1'b1;
      end else begin
        toutCnt <= '0;
      end
    end
  end

  assign en_pc    = ctl.enPc;
  assign en_fd    = ctl.enFd;
  assign flush_fd = ctl.flushFd;
  assign en_de    = ctl.enDe;
  assign flush_de = ctl.flushDe;
  assign en_em    = ctl.enEm;
  assign en_mw    = ctl.enMw;
  assign mem_err  = memErr;

  hazard_perf_counter #(.W(CNT_BITS)) uStallCnt (
    .clk(clk), .reset(reset), .en(~reset & ~ctl.enPc), .cnt(stall_cnt)
  );

  // Only redirects that take effect are counted; a frozen redirect is counted when it is re-presented.
  hazard_perf_counter #(.W(CNT_BITS)) uFlushCnt (
    .clk(clk), .reset(reset), .en(~reset & ~freeze & ex_redirect), .cnt(flush_cnt)
  );

endmodule
